// File: rtl/auth_msg_responder_if.sv
// Host-facing message channel of the authentication responder.
// master = host/driver side, slave = device responder.
interface auth_msg_responder_if #(
    parameter int MSG_LEN = 2080
);
    logic               resp_req_in;
    logic [MSG_LEN-1:0] auth_msg_in;
    logic [7:0]         pending_auth_request_PD;
    logic [7:0]         pending_auth_request_DEBUG;
    logic               Ack_in_driver;
    logic               resp_req_out;
    logic [MSG_LEN-1:0] auth_msg_out;
    logic               auth_msg_ready;
    logic               PD_in_ready;
    logic               DEBUG_in_ready;
    logic               pending_auth_request_PD_erase;
    logic               pending_auth_request_DEBUG_erase;
    logic [1:0]         erase_slot;
    logic               auth_error;

    modport master (
        output resp_req_in, auth_msg_in, pending_auth_request_PD,
               pending_auth_request_DEBUG, Ack_in_driver,
        input  resp_req_out, auth_msg_out, auth_msg_ready, PD_in_ready,
               DEBUG_in_ready, pending_auth_request_PD_erase,
               pending_auth_request_DEBUG_erase, erase_slot, auth_error
    );

    modport slave (
        input  resp_req_in, auth_msg_in, pending_auth_request_PD,
               pending_auth_request_DEBUG, Ack_in_driver,
        output resp_req_out, auth_msg_out, auth_msg_ready, PD_in_ready,
               DEBUG_in_ready, pending_auth_request_PD_erase,
               pending_auth_request_DEBUG_erase, erase_slot, auth_error
    );
endinterface

// File: rtl/auth_msg_responder.sv
// Device-side responder of the Type-C authentication message channel.
// Picks a pending request slot (PD first, then DEBUG, lowest index first),
// takes the request, validates its header, presents the response header
// until the host acks (with timed retries), then erases the served slot.
// Optional: define AUTH_DEBUG_CHANNEL_EN to also serve the DEBUG channel.
module auth_msg_responder #(
    parameter int          MSG_LEN     = 2080,
    parameter logic [15:0] MAX_CHUNK   = 16'h0100,
    parameter int          ACK_TIMEOUT = 64,
    parameter int          MAX_RETRY   = 3
) (
    input logic            clk,
    input logic            reset,
    auth_msg_responder_if.slave bus
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {IDLE, TAKE, CHECK, SEND, GAP, ERASE, DROP} state_t;

    state_t             state;
    logic               ch_q;        // 0 = PD, 1 = DEBUG
    logic [1:0]         slot_q;
    logic [1:0]         code_q;
    logic [MSG_LEN-1:0] req_buf;
    logic [MSG_LEN-1:0] msg_out;
    logic               rdy;
    logic               take;
    logic               erase;
    logic               err;
    logic [TW-1:0]      timer;
    logic [RW-1:0]      retry;

    logic [7:0]         dbg_slots;
    logic               sel_found;
    logic               sel_ch;
    logic [1:0]         sel_slot;
    logic [1:0]         sel_code;
    logic               req_ok;
    logic [15:0]        req_len;
    logic [15:0]        rsp_len;
    logic [MSG_LEN-1:0] resp;

`ifdef AUTH_DEBUG_CHANNEL_EN
    assign dbg_slots = bus.pending_auth_request_DEBUG;
`else
    // DEBUG slots never win arbitration when the channel is compiled out.
    assign dbg_slots = bus.pending_auth_request_DEBUG & 8'h00;
`endif

    // Slot arbitration: PD beats DEBUG, lower index beats higher.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = 1'b0;
        sel_slot  = 2'd0;
        sel_code  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (dbg_slots[2*i +: 2] != 2'b00) begin
                sel_found = 1'b1;
                sel_ch    = 1'b1;
                sel_slot  = 2'(i);
                sel_code  = dbg_slots[2*i +: 2];
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (bus.pending_auth_request_PD[2*i +: 2] != 2'b00) begin
                sel_found = 1'b1;
                sel_ch    = 1'b0;
                sel_slot  = 2'(i);
                sel_code  = bus.pending_auth_request_PD[2*i +: 2];
            end
        end
    end

    assign req_ok  = (req_buf[MSG_LEN-1 -: 8] == 8'h01) &&
                     (req_buf[MSG_LEN-9 -: 8] == {6'b100000, code_q});
    assign req_len = req_buf[MSG_LEN-49 -: 16];
    assign rsp_len = (req_len > MAX_CHUNK) ? MAX_CHUNK : req_len;

    // Response builder: echo p1/p2/offset and payload, clamp length; error frame otherwise.
    always_comb begin
        resp = '0;
        if (req_ok) begin
            resp[MSG_LEN-1  -: 8]  = 8'h01;
            resp[MSG_LEN-9  -: 8]  = {6'b0, code_q};
            resp[MSG_LEN-17 -: 32] = req_buf[MSG_LEN-17 -: 32];
            resp[MSG_LEN-49 -: 16] = rsp_len;
            resp[MSG_LEN-65:0]     = req_buf[MSG_LEN-65:0];
        end else begin
            resp[MSG_LEN-9  -: 8]  = 8'h7F;
            resp[MSG_LEN-17 -: 8]  = 8'h01;
        end
    end

    // Main FSM; pulses (take/erase) default low each cycle so they last one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ch_q    <= 1'b0;
            slot_q  <= 2'd0;
            code_q  <= 2'd0;
            req_buf <= '0;
            msg_out <= '0;
            rdy     <= 1'b0;
            take    <= 1'b0;
            erase   <= 1'b0;
            err     <= 1'b0;
            timer   <= '0;
            retry   <= '0;
        end else begin
            take  <= 1'b0;
            erase <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.resp_req_in && sel_found) begin
                        ch_q   <= sel_ch;
                        slot_q <= sel_slot;
                        code_q <= sel_code;
                        take   <= 1'b1;
                        state  <= TAKE;
                    end
                end
                TAKE: begin
                    req_buf <= bus.auth_msg_in;
                    state   <= CHECK;
                end
                CHECK: begin
                    msg_out <= resp;
                    rdy     <= 1'b1;
                    timer   <= '0;
                    state   <= SEND;
                end
                SEND: begin
                    if (bus.Ack_in_driver) begin
                        rdy   <= 1'b0;
                        erase <= 1'b1;
                        state <= ERASE;
                    end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                        rdy <= 1'b0;
                        if (retry == RW'(MAX_RETRY)) begin
                            erase <= 1'b1;
                            state <= DROP;
                        end else begin
                            retry <= retry + RW'(1);
                            state <= GAP;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP: begin
                    // one cycle with ready low before re-presenting the response
                    rdy   <= 1'b1;
                    timer <= '0;
                    state <= SEND;
                end
                ERASE: begin
                    retry <= '0;
                    state <= IDLE;
                end
                DROP: begin
                    err   <= 1'b1;
                    retry <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_req_out                  = take;
    assign bus.auth_msg_out                  = msg_out;
    assign bus.auth_msg_ready                = rdy;
    assign bus.PD_in_ready                   = rdy & ~ch_q;
    assign bus.pending_auth_request_PD_erase = erase & ~ch_q;
    assign bus.erase_slot                    = erase ? slot_q : 2'd0;
    assign bus.auth_error                    = err;
`ifdef AUTH_DEBUG_CHANNEL_EN
    assign bus.DEBUG_in_ready                   = rdy & ch_q;
    assign bus.pending_auth_request_DEBUG_erase = erase & ch_q;
`else
    assign bus.DEBUG_in_ready                   = 1'b0;
    assign bus.pending_auth_request_DEBUG_erase = 1'b0;
`endif
endmodule
